// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: signal bundle between the five-stage datapath and its hazard
//          controller. Clock and reset are kept outside as plain ports.
// Modports:
//   slave  - the controller: reads stage register/enable info, drives
//            write enables, bubble/flush, dmem_req, mem_error, counters
//   master - the datapath side (or a testbench): the mirror image
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_use_rn;
    logic                  id_use_rm;
    logic                  id_use_rd;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write_enable;
    logic                  ex_mem_enable;
    logic                  ex_mem_rw;
    logic                  ex_branch_taken;
    logic                  mem_mem_enable;
    logic                  dmem_ready;
    logic                  err_clr;

    logic                  pc_write_enable;
    logic                  if_id_write_enable;
    logic                  if_id_flush;
    logic                  id_ex_write_enable;
    logic                  id_ex_bubble;
    logic                  ex_mem_write_enable;
    logic                  mem_wb_write_enable;
    logic                  dmem_req;
    logic                  mem_error;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               ex_rd, ex_reg_write_enable, ex_mem_enable, ex_mem_rw,
               ex_branch_taken, mem_mem_enable, dmem_ready, err_clr,
        output pc_write_enable, if_id_write_enable, if_id_flush,
               id_ex_write_enable, id_ex_bubble, ex_mem_write_enable,
               mem_wb_write_enable, dmem_req, mem_error,
               stall_count, flush_count
    );

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               ex_rd, ex_reg_write_enable, ex_mem_enable, ex_mem_rw,
               ex_branch_taken, mem_mem_enable, dmem_ready, err_clr,
        input  pc_write_enable, if_id_write_enable, if_id_flush,
               id_ex_write_enable, id_ex_bubble, ex_mem_write_enable,
               mem_wb_write_enable, dmem_req, mem_error,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: pipeline sequencer for the five-stage ARM datapath. Handles
//          load-use stalls (1 cycle stall + ID/EX bubble), taken-branch
//          flushes, and whole-pipe freeze on data-memory wait states, with
//          a timeout FSM (RUN / MEM_WAIT / ERROR) and saturating stall and
//          flush event counters. Control outputs are combinational from
//          state and inputs, so they act in the same cycle.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   hz     - pipeline_hazard_ctrl_if.slave (stage info in, control out)
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic [REG_ADDR_W-1:0] rn, rm, rd, exd;
    logic                  load_use;
    logic                  req_core;
    logic                  freeze;

    // Control word before reset gating; the counters and FSM use this
    // version so reset never feeds the D side of its own flops.
    logic pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_bub, ex_mem_we, mem_wb_we;

    assign rn  = hz.id_rn;
    assign rm  = hz.id_rm;
    assign rd  = hz.id_rd;
    assign exd = hz.ex_rd;

    assign load_use = hz.ex_mem_enable & ~hz.ex_mem_rw & hz.ex_reg_write_enable &
                      ((hz.id_use_rn & (rn == exd)) |
                       (hz.id_use_rm & (rm == exd)) |
                       (hz.id_use_rd & (rd == exd)));

    assign req_core = hz.mem_mem_enable & (state != ST_ERROR);
    assign freeze   = req_core & ~hz.dmem_ready;

    always_comb begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        if_id_fl  = 1'b0;
        id_ex_we  = 1'b0;
        id_ex_bub = 1'b0;
        ex_mem_we = 1'b0;
        mem_wb_we = 1'b0;
        if (state == ST_ERROR) begin
            id_ex_bub = 1'b1;
        end else if (freeze) begin
            // whole pipe holds; a branch in EX stays put and is taken on release
        end else if (hz.ex_branch_taken) begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            if_id_fl  = 1'b1;
            id_ex_we  = 1'b1;
            id_ex_bub = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
        end else if (load_use) begin
            id_ex_we  = 1'b1;
            id_ex_bub = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
        end
    end

    // While reset is held the pipe loads NOPs and nothing advances.
    assign hz.pc_write_enable     = pc_we     & reset;
    assign hz.if_id_write_enable  = if_id_we  & reset;
    assign hz.if_id_flush         = if_id_fl  & reset;
    assign hz.id_ex_write_enable  = id_ex_we  & reset;
    assign hz.id_ex_bubble        = id_ex_bub | ~reset;
    assign hz.ex_mem_write_enable = ex_mem_we & reset;
    assign hz.mem_wb_write_enable = mem_wb_we & reset;
    assign hz.dmem_req            = req_core  & reset;
    assign hz.mem_error           = (state == ST_ERROR);
    assign hz.stall_count         = stall_q;
    assign hz.flush_count         = flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!freeze) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        // wait_cnt counts freeze cycles completed; the one
                        // that reaches MEM_TIMEOUT moves to ERROR
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state <= ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    if (hz.err_clr) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (!pc_we && (state != ST_ERROR) && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (if_id_fl && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end
endmodule
